// File: rtl/cache_bus_pkg.sv
// Shared definitions for the cache bus packet layout and the responder FSM.
// The cache and the memory responder both import this so the packet format has one source.
package cache_bus_pkg;

  localparam int unsigned addr_width_lp = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Packet is {we, addr, wdata}, MSB to LSB.
  function automatic int unsigned cache_bus_pkt_width(input int unsigned dma);
    return 1 + addr_width_lp + dma * 32;
  endfunction

  function automatic int unsigned wdata_offset(input int unsigned dma);
    return 0 * dma;
  endfunction

  function automatic int unsigned addr_offset(input int unsigned dma);
    return dma * 32;
  endfunction

  function automatic int unsigned we_offset(input int unsigned dma);
    return dma * 32 + addr_width_lp;
  endfunction

endpackage

// File: rtl/cache_bus_mem_if.sv
// Cache-to-memory bus: request packet with valid/yumi handshake and an
// unbackpressured read-data return path.
interface cache_bus_mem_if
  import cache_bus_pkg::*;
#(
  parameter int unsigned dma_data_width_p = 2
) ();

  logic                                               cb_valid_i;
  logic                                               cb_yumi_o;
  logic [cache_bus_pkt_width(dma_data_width_p)-1:0]   cb_pkt_i;
  logic                                               cb_valid_o;
  logic [dma_data_width_p*32-1:0]                     cb_data_o;

  modport master (
    output cb_valid_i, cb_pkt_i,
    input  cb_yumi_o, cb_valid_o, cb_data_o
  );

  modport slave (
    input  cb_valid_i, cb_pkt_i,
    output cb_yumi_o, cb_valid_o, cb_data_o
  );

endinterface

// File: rtl/cache_bus_mem_array.sv
// Beat-wide backing store: synchronous write, read captured into a data
// register that holds its value until the next read.
module cache_bus_mem_array #(
  parameter int unsigned depth_p = 2048,
  parameter int unsigned width_p = 64
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [$clog2(depth_p)-1:0] idx,
  input  logic [width_p-1:0]         wdata,
  output logic [width_p-1:0]         rdata
);

  logic [width_p-1:0] mem_r [depth_p];
  logic [width_p-1:0] rdata_r;

  // Array write port; contents deliberately survive reset
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_r[idx] <= wdata;
    end
  end

  // Read data register, loaded on a read accept and held otherwise
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_r <= {width_p{1'b0}};
    end else if (rd_en) begin
      rdata_r <= mem_r[idx];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/cache_bus_mem.sv
// Main-memory responder for the cache bus: commits writes immediately and
// returns read beats a fixed latency_p cycles after the read is accepted.
module cache_bus_mem
  import cache_bus_pkg::*;
#(
  parameter int unsigned dma_data_width_p = 2,
  parameter int unsigned mem_words_p      = 4096,
  parameter int unsigned latency_p        = 4
) (
  input  logic           clk_i,
  input  logic           reset_i,
  cache_bus_mem_if.slave cb
);

  localparam int unsigned beat_width_lp = dma_data_width_p * 32;
  localparam int unsigned beats_lp      = mem_words_p / dma_data_width_p;
  localparam int unsigned idx_width_lp  = $clog2(beats_lp);
  localparam int unsigned addr_off_lp   = addr_offset(dma_data_width_p);
  localparam int unsigned addr_lsb_lp   = addr_off_lp + $clog2(dma_data_width_p * 4);
  localparam int unsigned we_bit_lp     = we_offset(dma_data_width_p);
  localparam int unsigned wdata_off_lp  = wdata_offset(dma_data_width_p);
  localparam logic [7:0]  cnt_init_lp   = (latency_p > 1) ? 8'(latency_p - 2) : 8'd0;

  state_e                    state_r;
  logic [7:0]                cnt_r;
  logic                      valid_r;
  logic                      yumi_s;
  logic                      we_s;
  logic                      wr_en_s;
  logic                      rd_en_s;
  logic [idx_width_lp-1:0]   idx_s;
  logic [beat_width_lp-1:0]  wdata_s;
  logic [beat_width_lp-1:0]  rdata_s;
  logic                      unused_addr_s;

  // Beat index drops the byte-in-beat bits; upper address bits wrap silently.
  assign idx_s         = cb.cb_pkt_i[addr_lsb_lp +: idx_width_lp];
  assign we_s          = cb.cb_pkt_i[we_bit_lp];
  assign wdata_s       = cb.cb_pkt_i[wdata_off_lp +: beat_width_lp];
  assign unused_addr_s = ^cb.cb_pkt_i[addr_off_lp +: addr_width_lp];

  assign yumi_s  = cb.cb_valid_i & (state_r == IDLE) & ~reset_i;
  assign wr_en_s = yumi_s & we_s;
  assign rd_en_s = yumi_s & ~we_s;

  cache_bus_mem_array #(
    .depth_p (beats_lp),
    .width_p (beat_width_lp)
  ) u_array (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .wr_en   (wr_en_s),
    .rd_en   (rd_en_s),
    .idx     (idx_s),
    .wdata   (wdata_s),
    .rdata   (rdata_s)
  );

  // Read-latency FSM; valid_r is high exactly while the FSM sits in RESP
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (rd_en_s) begin
            cnt_r <= cnt_init_lp;
            if (latency_p == 1) begin
              state_r <= RESP;
              valid_r <= 1'b1;
            end else begin
              state_r <= WAIT;
              valid_r <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
            valid_r <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_r == 8'd0) begin
            state_r <= RESP;
            valid_r <= 1'b1;
          end else begin
            cnt_r   <= cnt_r - 8'd1;
            valid_r <= 1'b0;
          end
        end
        RESP: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 8'd0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign cb.cb_yumi_o  = yumi_s;
  assign cb.cb_valid_o = valid_r;
  assign cb.cb_data_o  = rdata_s;

endmodule

// File: tb/tb_cache_bus_mem.sv
// Bench for cache_bus_mem: a latency-4 and a latency-1 instance driven from a
// vector table, with a per-instance scoreboard of expected read responses.
module tb_cache_bus_mem;
  import cache_bus_pkg::*;

  localparam int unsigned dma_lp = 2;
  localparam int unsigned pw_lp  = cache_bus_pkt_width(dma_lp);

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  typedef struct {
    bit          which;   // 0: latency-4 instance, 1: latency-1 instance
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t q4[$];
  exp_t q1[$];
  exp_t e4, e1;
  int   prev_acc  = 0;
  bit   prev_rd   = 1'b0;
  bit   have_prev = 1'b0;
  vec_t vecs[15];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_bus_mem_if #(.dma_data_width_p(dma_lp)) if4 ();
  cache_bus_mem_if #(.dma_data_width_p(dma_lp)) if1 ();

  cache_bus_mem #(.dma_data_width_p(dma_lp), .mem_words_p(4096), .latency_p(4)) dut4 (
    .clk_i (clk), .reset_i (reset), .cb (if4)
  );
  cache_bus_mem #(.dma_data_width_p(dma_lp), .mem_words_p(4096), .latency_p(1)) dut1 (
    .clk_i (clk), .reset_i (reset), .cb (if1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (if4.cb_valid_o) begin
      if (q4.size() == 0) begin
        check("dut4_unexpected_valid", {63'd0, if4.cb_valid_o}, 64'd0);
      end else begin
        e4 = q4.pop_front();
        check("dut4_valid_cycle", 64'(cyc), 64'(e4.due));
        check("dut4_data", if4.cb_data_o, e4.data);
      end
    end else if (q4.size() != 0 && cyc > q4[0].due) begin
      e4 = q4.pop_front();
      check("dut4_missing_valid", {63'd0, if4.cb_valid_o}, 64'd1);
    end
  end

  always @(negedge clk) begin
    if (if1.cb_valid_o) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_valid", {63'd0, if1.cb_valid_o}, 64'd0);
      end else begin
        e1 = q1.pop_front();
        check("dut1_valid_cycle", 64'(cyc), 64'(e1.due));
        check("dut1_data", if1.cb_data_o, e1.data);
      end
    end else if (q1.size() != 0 && cyc > q1[0].due) begin
      e1 = q1.pop_front();
      check("dut1_missing_valid", {63'd0, if1.cb_valid_o}, 64'd1);
    end
  end

  // Present one packet, hold it until yumi, check accept timing, log expected read.
  task automatic drive(input vec_t v);
    int                lat = v.which ? 1 : 4;
    bit                ok  = 1'b0;
    logic              y   = 1'b0;
    logic [pw_lp-1:0]  pkt;
    pkt = {v.we, v.addr, v.wdata};
    if (v.which) begin
      if1.cb_valid_i = 1'b1;
      if1.cb_pkt_i   = pkt;
    end else begin
      if4.cb_valid_i = 1'b1;
      if4.cb_pkt_i   = pkt;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      y = v.which ? if1.cb_yumi_o : if4.cb_yumi_o;
      if (y) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", {63'd0, y}, 64'd1);
    end else begin
      if (have_prev) begin
        check("accept_cycle", 64'(cyc), 64'(prev_acc + (prev_rd ? lat + 1 : 1)));
      end
      if (!v.we) begin
        if (v.which) q1.push_back('{data: v.exp, due: cyc + lat});
        else         q4.push_back('{data: v.exp, due: cyc + lat});
      end
      prev_acc  = cyc;
      prev_rd   = !v.we;
      have_prev = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    if4.cb_valid_i = 1'b0;
    if1.cb_valid_i = 1'b0;
    have_prev      = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (q4.size() == 0 && q1.size() == 0) break;
    end
    if (q4.size() != 0 || q1.size() != 0) begin
      check("drain_timeout", 64'(q4.size() + q1.size()), 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0040, 64'hBBBB_0001_AAAA_0000, 64'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_0040, 64'h0, 64'hBBBB_0001_AAAA_0000};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0000, 64'h0000_0000_0000_0011, 64'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0000_4000, 64'h0, 64'h0000_0000_0000_0011};
    vecs[4]  = '{1'b0, 1'b0, 32'h0000_0047, 64'h0, 64'hBBBB_0001_AAAA_0000};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_3FF8, 64'h0123_4567_89AB_CDEF, 64'h0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0000_FFF8, 64'h0, 64'h0123_4567_89AB_CDEF};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0018, 64'h0000_0000_5555_AAAA, 64'h0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0000_0018, 64'h0, 64'h0000_0000_5555_AAAA};
    vecs[9]  = '{1'b0, 1'b0, 32'h0000_0100, 64'h0, 64'hCAFE_F00D_0BAD_BEEF};
    vecs[10] = '{1'b1, 1'b1, 32'h0000_0008, 64'h1234_5678_9ABC_DEF0, 64'h0};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0008, 64'h0, 64'h1234_5678_9ABC_DEF0};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0008, 64'h0, 64'h1234_5678_9ABC_DEF0};
    vecs[13] = '{1'b1, 1'b1, 32'h0000_000C, 64'hFFFF_0000_FFFF_0000, 64'h0};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_0008, 64'h0, 64'hFFFF_0000_FFFF_0000};

    // Reset with a write already presented: nothing may be consumed or returned.
    if4.cb_valid_i = 1'b1;
    if4.cb_pkt_i   = {1'b1, 32'h0000_0100, 64'hCAFE_F00D_0BAD_BEEF};
    if1.cb_valid_i = 1'b0;
    if1.cb_pkt_i   = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_yumi",  {63'd0, if4.cb_yumi_o},  64'd0);
      check("rst_valid", {63'd0, if4.cb_valid_o}, 64'd0);
      check("rst_data",  if4.cb_data_o,           64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    c0 = cyc;
    drive('{1'b0, 1'b1, 32'h0000_0100, 64'hCAFE_F00D_0BAD_BEEF, 64'h0});
    check("first_accept_cycle", 64'(prev_acc), 64'(c0));

    for (int i = 0; i < 15; i++) begin
      if (i > 0 && vecs[i].which != vecs[i-1].which) go_idle();
      drive(vecs[i]);
    end
    go_idle();
    drain();

    repeat (2) @(posedge clk);
    #1;
    check("dut4_data_hold", if4.cb_data_o, 64'hCAFE_F00D_0BAD_BEEF);
    check("dut1_data_hold", if1.cb_data_o, 64'hFFFF_0000_FFFF_0000);

    // Reset while a read is in WAIT: response abandoned, array preserved.
    drive('{1'b0, 1'b0, 32'h0000_0040, 64'h0, 64'hBBBB_0001_AAAA_0000});
    if4.cb_valid_i = 1'b0;
    reset = 1'b1;
    q4.delete();
    have_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_wait_no_valid", {63'd0, if4.cb_valid_o}, 64'd0);
    end
    @(posedge clk);
    #1;
    drive('{1'b0, 1'b0, 32'h0000_0040, 64'h0, 64'hBBBB_0001_AAAA_0000});
    drive('{1'b0, 1'b0, 32'h0000_0000, 64'h0, 64'h0000_0000_0000_0011});
    go_idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
